stack_sequencer: RTL and testbench

- Control-side initiator for the stack pointer: turns PUSH/POP/CALL/RET/LDSP commands into the stack pointer's active-low strobes (outn, loadn, cupn, cdownn) and into memory read/write strobes.
- Sits between the instruction control logic and the stack pointer plus RAM; owns the stack's byte order and the order in which the pointer moves relative to each access.
- Full-descending stack: decrement then write; read then increment.

---
 rtl/stack_sequencer.sv | 141 ++++++++++++++
 tb/tb_stack_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
// stack_sequencer: drives stack-pointer strobes and RAM strobes for a full-descending byte stack.
// Optional depth/bounds checking is enabled by defining STACK_BOUNDS_EN.
module stack_sequencer #(
    parameter int DEPTH_MAX = 256
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd,
    output logic        cmd_ready,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        rdata_valid,
    output logic        sp_outn,
    output logic        sp_loadn,
    output logic        sp_cupn,
    output logic        sp_cdownn,
    output logic [15:0] abus_out,
    output logic        abus_oe,
    output logic        mem_wen,
    output logic        mem_oen,
    output logic [7:0]  dbus_out,
    output logic        dbus_oe,
    input  logic [7:0]  dbus_in,
    output logic        err
);
    localparam logic [2:0] S_IDLE = 3'd0, S_DEC = 3'd1, S_WR = 3'd2, S_RD = 3'd3, S_INC = 3'd4, S_LOAD = 3'd5;
    localparam logic [2:0] C_PUSH = 3'd1, C_POP = 3'd2, C_CALL = 3'd3, C_RET = 3'd4, C_LDSP = 3'd5;

    if (DEPTH_MAX < 1 || DEPTH_MAX > 65535) begin : g_bad_depth
        $error("stack_sequencer: DEPTH_MAX must be in 1..65535");
    end

    logic [2:0]  state_q, state_d, op_q, op_d;
    logic        idx_q, idx_d, rvalid_q, rvalid_d;
    logic [15:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic        accept, viol, last_inc;

    assign cmd_ready = state_q == S_IDLE;
    assign accept    = cmd_valid && cmd_ready;
    // A RET only returns to IDLE after its second increment.
    assign last_inc  = !(op_q == C_RET && !idx_q);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        case (state_q)
            S_IDLE: if (accept) begin
                op_d    = cmd;
                wdata_d = wdata;
                idx_d   = 1'b0;
                state_d = viol ? S_IDLE :
                          (cmd == C_PUSH || cmd == C_CALL) ? S_DEC :
                          (cmd == C_POP  || cmd == C_RET)  ? S_RD  :
                          (cmd == C_LDSP) ? S_LOAD : S_IDLE;
            end
            S_DEC:  state_d = S_WR;
            S_WR: begin
                state_d = (op_q == C_CALL && !idx_q) ? S_DEC : S_IDLE;
                idx_d   = 1'b1;
            end
            S_RD: begin
                rdata_d = idx_q ? {dbus_in, rdata_q[7:0]} : {8'h00, dbus_in};
                state_d = S_INC;
            end
            S_INC: begin
                state_d  = last_inc ? S_IDLE : S_RD;
                rvalid_d = last_inc;
                idx_d    = 1'b1;
            end
            S_LOAD: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            idx_q    <= 1'b0;
            wdata_q  <= 16'h0000;
            rdata_q  <= 16'h0000;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

`ifdef STACK_BOUNDS_EN
    logic [15:0] depth_q, depth_d;
    logic        err_q, err_d;

    assign viol = (cmd == C_PUSH && int'(depth_q) > DEPTH_MAX - 1) ||
                  (cmd == C_CALL && int'(depth_q) > DEPTH_MAX - 2) ||
                  (cmd == C_POP  && depth_q < 16'd1) ||
                  (cmd == C_RET  && depth_q < 16'd2);

    // Depth follows bytes actually moved, so it updates on each WR/RD cycle.
    assign depth_d = (state_q == S_LOAD) ? 16'd0 :
                     (state_q == S_WR)   ? depth_q + 16'd1 :
                     (state_q == S_RD)   ? depth_q - 16'd1 : depth_q;
    assign err_d   = (state_q == S_LOAD) ? 1'b0 : (accept && viol) ? 1'b1 : err_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            depth_q <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;
`else
    assign viol = 1'b0;
    assign err  = 1'b0;
`endif

    assign sp_cdownn   = state_q != S_DEC;
    assign sp_cupn     = state_q != S_INC;
    assign sp_loadn    = state_q != S_LOAD;
    assign sp_outn     = !(state_q == S_WR || state_q == S_RD);
    assign mem_wen     = state_q != S_WR;
    assign mem_oen     = state_q != S_RD;
    assign dbus_oe     = state_q == S_WR;
    assign abus_oe     = state_q == S_LOAD;
    assign abus_out    = wdata_q;
    assign dbus_out    = (op_q == C_CALL && !idx_q) ? wdata_q[15:8] : wdata_q[7:0];
    assign rdata       = rdata_q;
    assign rdata_valid = rvalid_q;
endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer: random and directed commands checked against a command-level stack model.
module tb_stack_sequencer;
`ifdef STACK_BOUNDS_EN
  localparam int DMAX = 2;
`else
  localparam int DMAX = 256;
`endif
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd = 3'd0;
  logic [15:0] wdata = 16'h0;
  logic        cmd_ready, rdata_valid, sp_outn, sp_loadn, sp_cupn, sp_cdownn;
  logic        abus_oe, mem_wen, mem_oen, dbus_oe, err;
  logic [15:0] rdata, abus_out;
  logic [7:0]  dbus_out, dbus_in;
  int tests = 0;
  int fails = 0;
  task automatic check(input string tag, input logic ok);
    tests++;
    if (ok !== 1'b1) begin
      fails++;
      $error("FAIL %s", tag);
    end
  endtask
  stack_sequencer #(.DEPTH_MAX(DMAX)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid),
    .sp_outn(sp_outn), .sp_loadn(sp_loadn), .sp_cupn(sp_cupn), .sp_cdownn(sp_cdownn),
    .abus_out(abus_out), .abus_oe(abus_oe), .mem_wen(mem_wen), .mem_oen(mem_oen),
    .dbus_out(dbus_out), .dbus_oe(dbus_oe), .dbus_in(dbus_in), .err(err)
  );
  always #5 clk = ~clk;
  logic [15:0] sp = 16'h0000;
  logic [7:0]  ram [0:65535];
  assign dbus_in = ram[sp];
  logic [15:0] m_sp = 16'h0000;
  logic [7:0]  m_ram [0:65535];
  int          m_depth = 0;
  logic        m_err = 1'b0;
  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]   = 8'(i) ^ 8'h5A;
      m_ram[i] = 8'(i) ^ 8'h5A;
    end
    forever begin
      @(posedge clk);
      if (!sp_loadn && abus_oe) sp <= abus_out;
      else if (!sp_cdownn) sp <= sp - 16'd1;
      else if (!sp_cupn) sp <= sp + 16'd1;
      if (!mem_wen && dbus_oe) ram[sp] <= dbus_out;
    end
  end
  always @(negedge clk) begin
    if (resetn)
      check("invariants", {$countones({~sp_loadn, ~sp_cupn, ~sp_cdownn}) <= 1,
                           !(!sp_outn && !sp_loadn), !(!mem_wen && !mem_oen),
                           !dbus_oe || !mem_wen, !abus_oe || !sp_loadn} === 5'b11111);
  end
  task automatic run(input logic [2:0] c, input logic [15:0] d);
    int lat = 1, n = 0, moves = 0, wrs = 0, rds = 0, e_moves = 0, e_wrs = 0, e_rds = 0;
    logic viol = 1'b0, rv = 1'b0;
    logic [15:0] rexp = 16'h0, wr_addr = 16'h0;
`ifdef STACK_BOUNDS_EN
    viol = (c == 3'd1 && m_depth > DMAX - 1) || (c == 3'd3 && m_depth > DMAX - 2) ||
           (c == 3'd2 && m_depth < 1) || (c == 3'd4 && m_depth < 2);
`endif
    if (viol) m_err = 1'b1;
    else case (c)
      3'd1: begin
        m_sp--; m_ram[m_sp] = d[7:0]; m_depth += 1;
        lat = 3; e_moves = 1; e_wrs = 1;
      end
      3'd2: begin
        rexp = {8'h00, m_ram[m_sp]}; m_sp++; m_depth -= 1;
        lat = 3; e_moves = 1; e_rds = 1; rv = 1'b1;
      end
      3'd3: begin
        m_sp--; m_ram[m_sp] = d[15:8]; m_sp--; m_ram[m_sp] = d[7:0]; m_depth += 2;
        lat = 5; e_moves = 2; e_wrs = 2;
      end
      3'd4: begin
        rexp[7:0] = m_ram[m_sp]; m_sp++; rexp[15:8] = m_ram[m_sp]; m_sp++; m_depth -= 2;
        lat = 5; e_moves = 2; e_rds = 2; rv = 1'b1;
      end
      3'd5: begin
        m_sp = d; m_depth = 0; m_err = 1'b0;
        lat = 2; e_moves = 1;
      end
      default: lat = 1;
    endcase
    @(negedge clk);
    check("ready_before", cmd_ready === 1'b1);
    check("rvalid_one_cycle", rdata_valid === 1'b0);
    cmd_valid = 1'b1; cmd = c; wdata = d;
    @(posedge clk);
    #1;
    cmd = 3'($urandom); wdata = 16'($urandom);
    do begin
      @(negedge clk);
      n++;
      moves += int'(!sp_loadn) + int'(!sp_cupn) + int'(!sp_cdownn);
      wrs += int'(!mem_wen);
      rds += int'(!mem_oen);
      if (!mem_wen) wr_addr = sp;
    end while (!cmd_ready && n < 20);
    cmd_valid = 1'b0;
    check("latency", n == lat);
    check("sp_moves", moves == e_moves);
    check("writes", wrs == e_wrs);
    check("reads", rds == e_rds);
    check("sp", sp === m_sp);
    check("err", err === m_err);
    check("rdata_valid", rdata_valid === rv);
    check("ram_top", ram[m_sp] === m_ram[m_sp]);
    check("ram_next", ram[m_sp + 16'd1] === m_ram[m_sp + 16'd1]);
    if (rv) check("rdata", rdata === rexp);
    if (e_wrs > 0) check("wr_addr", wr_addr === m_sp);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready === 1'b1);
    check("rst_strobes", {sp_outn, sp_loadn, sp_cupn, sp_cdownn, mem_wen, mem_oen} === 6'h3F);
    check("rst_oe", {abus_oe, dbus_oe, rdata_valid, err} === 4'h0);
    check("rst_rdata", rdata === 16'h0000);
    resetn = 1'b1;
    run(3'd5, 16'h0100);
    run(3'd1, 16'h33A5);
    check("push_ram", ram[16'h00FF] === 8'hA5);
    run(3'd2, 16'h0000);
    check("pop_sp", sp === 16'h0100);
    run(3'd5, 16'h0000);
    run(3'd3, 16'hBEEF);
    check("call_hi", ram[16'hFFFF] === 8'hBE);
    check("call_lo", ram[16'hFFFE] === 8'hEF);
    run(3'd4, 16'h0000);
    check("ret_sp", sp === 16'h0000);
    run(3'd7, 16'hFFFF);
    run(3'd0, 16'h1234);
    run(3'd6, 16'h5678);
    run(3'd5, 16'h0000);
    run(3'd3, 16'hCAFE);
    run(3'd1, 16'h0011);
    run(3'd5, 16'h0300);
    check("err_cleared", err === 1'b0);
    run(3'd5, 16'h2000);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 3'd3; wdata = 16'h1234;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("second_dec", sp_cdownn === 1'b0);
    #1 resetn = 1'b0;
    #1;
    check("mid_rst_strobes", {sp_outn, sp_loadn, sp_cupn, sp_cdownn, mem_wen, mem_oen} === 6'h3F);
    check("mid_rst_ready", cmd_ready === 1'b1);
    check("mid_rst_rdata", rdata === 16'h0000);
    check("mid_rst_oe", {abus_oe, dbus_oe, rdata_valid, err} === 4'h0);
    @(negedge clk);
    resetn = 1'b1;
    m_sp = 16'h1FFF; m_ram[16'h1FFF] = 8'h12; m_depth = 0; m_err = 1'b0;
    check("mid_rst_sp", sp === 16'h1FFF);
    check("mid_rst_ram", ram[16'h1FFF] === 8'h12);
    repeat (300) run(3'($urandom_range(0, 7)), 16'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
